// File: rtl/mii_rx_frame.sv
// MII receive framer: strips preamble/SFD, packs nibbles into bytes, frames them with sof/eof/err.
// Optional CRC-32 FCS checking is compiled in when MII_RX_CRC_EN is defined.
module mii_rx_frame #(
  parameter int MIN_PRE = 4,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_dv,
  input  logic [3:0]  rxd,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_err,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt,
  output logic [1:0]  state_dbg
);

  // Output handshake: out_valid is a one-cycle strobe with no ready; sof/eof/err
  // are meaningful only while out_valid is high, and bytes arrive at most every 2 clk.
  typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, DATA = 2'd2, DROP = 2'd3} state_t;

  state_t      state;
  logic [3:0]  pre_cnt;
  logic        phase;
  logic [3:0]  low_nib;
  logic [7:0]  hold_data;
  logic        hold_valid;
  logic        hold_first;
  logic [10:0] byte_cnt;
  logic        crc_bad;
  logic        frame_bad;

  assign state_dbg = state;

`ifdef MII_RX_CRC_EN
  logic [31:0] crc;

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Register runs over every completed byte, FCS included, so a good frame leaves the residue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) crc <= 32'hFFFFFFFF;
    else if (state != DATA) crc <= 32'hFFFFFFFF;
    else if (rx_dv && phase) crc <= crc_next(crc, {rxd, low_nib});
  end

  assign crc_bad = (crc != 32'hDEBB20E3);
`else
  assign crc_bad = 1'b0;
`endif

  assign frame_bad = phase | (byte_cnt < 11'(MIN_LEN)) | crc_bad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pre_cnt    <= 4'd0;
      phase      <= 1'b0;
      low_nib    <= 4'd0;
      hold_data  <= 8'd0;
      hold_valid <= 1'b0;
      hold_first <= 1'b0;
      byte_cnt   <= 11'd0;
      out_data   <= 8'd0;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_err    <= 1'b0;
      frame_cnt  <= 16'd0;
      err_cnt    <= 16'd0;
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_err   <= 1'b0;
      case (state)
        IDLE: begin
          phase      <= 1'b0;
          hold_valid <= 1'b0;
          hold_first <= 1'b0;
          byte_cnt   <= 11'd0;
          if (rx_dv) begin
            if (rxd == 4'h5) begin
              state   <= PRE;
              pre_cnt <= 4'd1;
            end else begin
              // Joined mid-frame: wait for the carrier to drop.
              state <= DROP;
            end
          end
        end
        PRE: begin
          if (!rx_dv) state <= IDLE;
          else if (rxd == 4'h5) begin
            if (pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;
          end else if (rxd == 4'hD && pre_cnt >= 4'(MIN_PRE)) state <= DATA;
          else state <= DROP;
        end
        DATA: begin
          if (!rx_dv) begin
            state <= IDLE;
            if (hold_valid) begin
              out_valid <= 1'b1;
              out_data  <= hold_data;
              out_sof   <= hold_first;
              out_eof   <= 1'b1;
              out_err   <= frame_bad;
              if (frame_bad) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
              end else begin
                if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
              end
            end else begin
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
          end else if (!phase) begin
            low_nib <= rxd;
            phase   <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (byte_cnt == 11'(MAX_LEN)) begin
              // Giant: the held byte is the last legal one, close the frame as bad.
              state     <= DROP;
              out_valid <= 1'b1;
              out_data  <= hold_data;
              out_sof   <= hold_first;
              out_eof   <= 1'b1;
              out_err   <= 1'b1;
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end else begin
              if (hold_valid) begin
                out_valid <= 1'b1;
                out_data  <= hold_data;
                out_sof   <= hold_first;
              end
              hold_data  <= {rxd, low_nib};
              hold_first <= (byte_cnt == 11'd0);
              hold_valid <= 1'b1;
              if (byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
            end
          end
        end
        DROP: begin
          if (!rx_dv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
